lsfr_tick_timer: RTL and testbench

Consumes the slow toggle output of the LFSR clock divider, turns each qualifying edge into a single-cycle tick, and counts ticks as a BCD mm:ss timer. Each timer change is published through a one-entry valid/ready output register to the display/UART stage. Overwrites of an unaccepted snapshot are counted. Sits directly downstream of the divider, in the same clock domain.

---
 rtl/lsfr_pkg.sv | 19 +
 rtl/lsfr_tick_timer_if.sv | 9 +
 rtl/bcd_mod60_counter.sv | 35 +++
 rtl/lsfr_tick_timer.sv | 102 ++++++++++
 tb/tb_lsfr_tick_timer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsfr_pkg.sv
// Shared BCD types, limits and the mod-60 field check used by the tick timer.
package lsfr_pkg;

  localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

  typedef logic [7:0] bcd8_t;

  typedef struct packed {
    bcd8_t min;
    bcd8_t sec;
  } snap_t;

  // A field is usable as minutes or seconds only if it is a legal 00..59 BCD pair.
  function automatic logic bcd_valid60(bcd8_t v);
    return (v[7:4] <= BCD_MAX_TENS) && (v[3:0] <= BCD_MAX_UNITS);
  endfunction

endpackage

// File: rtl/lsfr_tick_timer_if.sv
// One-entry snapshot stream from the tick timer to the display/UART stage.
interface lsfr_tick_timer_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  modport master (output out_valid, output out_data, input  out_ready);
  modport slave  (input  out_valid, input  out_data, output out_ready);
endinterface

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD counter 00..59; carry is combinational so a cascaded stage
// advances in the same cycle the lower stage rolls over.
module bcd_mod60_counter
  import lsfr_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  load,
  input  bcd8_t load_val,
  input  logic  inc,
  output bcd8_t value,
  output logic  carry
);

  assign carry = inc && (value[7:4] == BCD_MAX_TENS) && (value[3:0] == BCD_MAX_UNITS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      if (value[3:0] == BCD_MAX_UNITS) begin
        value[3:0] <= 4'd0;
        value[7:4] <= (value[7:4] == BCD_MAX_TENS) ? 4'd0 : value[7:4] + 4'd1;
      end else begin
        value[3:0] <= value[3:0] + 4'd1;
      end
    end
  end

endmodule

// File: rtl/lsfr_tick_timer.sv
// Turns divider toggles into ticks, counts them as BCD mm:ss and publishes
// every timer change through a one-entry register that counts overwrites.
module lsfr_tick_timer
  import lsfr_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b0,
  parameter int DROP_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              div_in,
  input  logic              en,
  input  logic              clr,
  input  logic              load,
  input  bcd8_t             load_min,
  input  bcd8_t             load_sec,
  output logic              tick,
  output bcd8_t             sec_bcd,
  output bcd8_t             min_bcd,
  output logic              wrap,
  output logic              load_err,
  output logic [DROP_W-1:0] drop_cnt,
  lsfr_tick_timer_if.master out_if
);

  logic  prev, armed;
  logic  edge_det, load_ok, cnt_load, cnt_inc, publish, pub_q;
  logic  sec_carry, min_carry;
  snap_t snap;

  always_comb begin
    edge_det = armed & ((div_in & ~prev) | (EDGE_MODE & ~div_in & prev));
    load_ok  = bcd_valid60(load_min) & bcd_valid60(load_sec);
    cnt_load = ~clr & load & load_ok;
    // A rejected load still outranks the increment, so the timer holds.
    cnt_inc  = ~clr & ~load & en & edge_det;
    publish  = clr | cnt_load | cnt_inc;
  end

  bcd_mod60_counter u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (cnt_load),
    .load_val (load_sec),
    .inc      (cnt_inc),
    .value    (sec_bcd),
    .carry    (sec_carry)
  );

  bcd_mod60_counter u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (cnt_load),
    .load_val (load_min),
    .inc      (sec_carry),
    .value    (min_bcd),
    .carry    (min_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev     <= 1'b0;
      armed    <= 1'b0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      pub_q    <= 1'b0;
    end else begin
      prev     <= div_in;
      armed    <= 1'b1;
      tick     <= edge_det;
      wrap     <= min_carry;
      load_err <= ~clr & load & ~load_ok;
      pub_q    <= publish;
    end
  end

  // Snapshot is taken one cycle after the change, once the counters hold it.
  assign snap = '{min: min_bcd, sec: sec_bcd};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_if.out_valid <= 1'b0;
      out_if.out_data  <= '0;
      drop_cnt         <= '0;
    end else begin
      if (pub_q) begin
        out_if.out_data  <= snap;
        out_if.out_valid <= 1'b1;
        if (out_if.out_valid && !out_if.out_ready && (drop_cnt != '1))
          drop_cnt <= drop_cnt + 1'b1;
      end else if (out_if.out_valid && out_if.out_ready) begin
        out_if.out_valid <= 1'b0;
      end
      if (clr)
        drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_lsfr_tick_timer.sv
// Directed plus random checks of both edge modes against an integer-seconds model.
module tb_lsfr_tick_timer;
  import lsfr_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, div_in, en, clr, load, out_ready;
  logic [7:0] load_min, load_sec;

  logic       tick_o [2];
  logic [7:0] sec_o  [2];
  logic [7:0] min_o  [2];
  logic       wrap_o [2];
  logic       lerr_o [2];
  logic [3:0] drop_o [2];
  logic       vld_o  [2];
  logic [15:0] data_o [2];

  int checks = 0;
  int errors = 0;

  // Behavioural model state: timer kept as total seconds.
  int          secs  [2];
  int          drops [2];
  bit          armed [2];
  bit          prv   [2];
  bit          e_tick[2], e_wrap[2], e_lerr[2], e_valid[2], pend[2];
  logic [15:0] e_data[2], pdata[2];

  always #5 clk = ~clk;

  lsfr_tick_timer_if if0 ();
  lsfr_tick_timer_if if1 ();
  assign if0.out_ready = out_ready;
  assign if1.out_ready = out_ready;
  assign vld_o[0] = if0.out_valid;
  assign vld_o[1] = if1.out_valid;
  assign data_o[0] = if0.out_data;
  assign data_o[1] = if1.out_data;

  lsfr_tick_timer #(.EDGE_MODE(1'b0), .DROP_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .div_in(div_in), .en(en), .clr(clr), .load(load),
    .load_min(load_min), .load_sec(load_sec), .tick(tick_o[0]), .sec_bcd(sec_o[0]),
    .min_bcd(min_o[0]), .wrap(wrap_o[0]), .load_err(lerr_o[0]), .drop_cnt(drop_o[0]),
    .out_if(if0.master)
  );

  lsfr_tick_timer #(.EDGE_MODE(1'b1), .DROP_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .div_in(div_in), .en(en), .clr(clr), .load(load),
    .load_min(load_min), .load_sec(load_sec), .tick(tick_o[1]), .sec_bcd(sec_o[1]),
    .min_bcd(min_o[1]), .wrap(wrap_o[1]), .load_err(lerr_o[1]), .drop_cnt(drop_o[1]),
    .out_if(if1.master)
  );

  function automatic bit v60(logic [7:0] v);
    int t, u;
    t = int'(v) / 16;
    u = int'(v) % 16;
    return (t <= 5) && (u <= 9);
  endfunction

  function automatic int bcd2int(logic [7:0] v);
    return (int'(v) / 16) * 10 + int'(v) % 16;
  endfunction

  function automatic logic [15:0] to_bcd(int s);
    int m, q;
    m = s / 60;
    q = s % 60;
    return 16'((m / 10) * 4096 + (m % 10) * 256 + (q / 10) * 16 + (q % 10));
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      bit edg;
      if (!rst_n) begin
        secs[m] = 0; drops[m] = 0; armed[m] = 0; prv[m] = 0;
        e_tick[m] = 0; e_wrap[m] = 0; e_lerr[m] = 0; e_valid[m] = 0;
        e_data[m] = '0; pend[m] = 0; pdata[m] = '0;
      end else begin
        edg = armed[m] && ((div_in && !prv[m]) || (m == 1 && !div_in && prv[m]));
        e_tick[m] = edg;
        armed[m]  = 1;
        prv[m]    = div_in;
        if (pend[m]) begin
          if (e_valid[m] && !out_ready) drops[m] = (drops[m] == 15) ? 15 : drops[m] + 1;
          e_data[m]  = pdata[m];
          e_valid[m] = 1;
        end else if (e_valid[m] && out_ready) begin
          e_valid[m] = 0;
        end
        e_wrap[m] = 0; e_lerr[m] = 0; pend[m] = 0;
        if (clr) begin
          secs[m] = 0; drops[m] = 0; pend[m] = 1;
        end else if (load) begin
          if (v60(load_min) && v60(load_sec)) begin
            secs[m] = bcd2int(load_min) * 60 + bcd2int(load_sec);
            pend[m] = 1;
          end else begin
            e_lerr[m] = 1;
          end
        end else if (edg && en) begin
          pend[m] = 1;
          if (secs[m] == 3599) begin secs[m] = 0; e_wrap[m] = 1; end
          else secs[m]++;
        end
        pdata[m] = to_bcd(secs[m]);
      end
    end
  endtask

  // One clock: advance the model at the edge, compare every output 1 ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("tick%0d", m),  16'(tick_o[m]), 16'(e_tick[m]));
      chk($sformatf("timer%0d", m), {min_o[m], sec_o[m]}, to_bcd(secs[m]));
      chk($sformatf("wrap%0d", m),  16'(wrap_o[m]), 16'(e_wrap[m]));
      chk($sformatf("lerr%0d", m),  16'(lerr_o[m]), 16'(e_lerr[m]));
      chk($sformatf("valid%0d", m), 16'(vld_o[m]),  16'(e_valid[m]));
      chk($sformatf("data%0d", m),  data_o[m],      e_data[m]);
      chk($sformatf("drop%0d", m),  16'(drop_o[m]), 16'(drops[m]));
    end
  endtask

  task automatic toggle(int n);
    for (int i = 0; i < n; i++) begin
      div_in = ~div_in;
      step();
    end
  endtask

  initial begin
    int tcount;
    rst_n = 0; div_in = 1; en = 1; clr = 0; load = 0;
    load_min = '0; load_sec = '0; out_ready = 1;

    // Reset with div_in held high; no tick on release.
    repeat (3) step();
    chk("rst_valid", 16'(vld_o[0]), 16'd0);
    rst_n = 1;
    step();
    step();
    chk("no_tick_after_rst", 16'(tick_o[0]), 16'd0);
    div_in = 0; step();
    div_in = 1; step();
    chk("first_tick", 16'(tick_o[0]), 16'd1);
    chk("first_sec", 16'(sec_o[0]), 16'h01);
    step();
    chk("first_snap", data_o[0], 16'h0001);

    // Rollover from 59:58.
    load = 1; load_min = 8'h59; load_sec = 8'h58; step();
    load = 0;
    div_in = 0; step();
    div_in = 1; step();
    chk("roll_5959", {min_o[0], sec_o[0]}, 16'h5959);
    div_in = 0; step();
    div_in = 1; step();
    chk("roll_0000", {min_o[0], sec_o[0]}, 16'h0000);
    chk("roll_wrap", 16'(wrap_o[0]), 16'd1);
    step();
    chk("wrap_pulse", 16'(wrap_o[0]), 16'd0);
    step();

    // Rejected and accepted loads.
    load = 1; load_min = 8'h12; load_sec = 8'h6A; step();
    load = 0;
    chk("load_err", 16'(lerr_o[0]), 16'd1);
    step(); step();
    load = 1; load_sec = 8'h45; step();
    load = 0;
    chk("load_ok", {min_o[0], sec_o[0]}, 16'h1245);
    step();

    // clr beats load and tick in the same cycle.
    div_in = 0; step();
    clr = 1; load = 1; load_min = 8'h33; load_sec = 8'h22; div_in = 1; step();
    clr = 0; load = 0;
    chk("prio_tick", 16'(tick_o[0]), 16'd1);
    chk("prio_timer", {min_o[0], sec_o[0]}, 16'h0000);
    chk("prio_drop", 16'(drop_o[0]), 16'd0);
    step();
    chk("prio_snap", data_o[0], 16'h0000);
    step(); step();

    // Stall for 20 rising edges.
    out_ready = 0;
    toggle(40);
    step();
    chk("stall_data", data_o[0], 16'h0020);
    chk("stall_drop", 16'(drop_o[0]), 16'd15);
    out_ready = 1;
    chk("stall_xfer", data_o[0], 16'h0020);
    step();
    chk("stall_drained", 16'(vld_o[0]), 16'd0);

    // Enable gating with both-edge mode.
    clr = 1; step(); clr = 0; step();
    en = 0; tcount = 0;
    for (int i = 0; i < 4; i++) begin
      div_in = ~div_in; step();
      if (tick_o[1] === 1'b1) tcount++;
    end
    chk("en0_ticks", 16'(tcount), 16'd4);
    chk("en0_timer", {min_o[1], sec_o[1]}, 16'h0000);
    en = 1;
    toggle(4);
    chk("en1_sec", 16'(sec_o[1]), 16'h04);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 63) != 0);
      div_in    = 1'($urandom);
      en        = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 31) == 0);
      load      = ($urandom_range(0, 15) == 0);
      load_min  = $urandom_range(0, 1) ? 8'(($urandom_range(0, 5) << 4) | $urandom_range(0, 9)) : 8'($urandom);
      load_sec  = $urandom_range(0, 1) ? 8'(($urandom_range(0, 5) << 4) | $urandom_range(0, 9)) : 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
